// File: rtl/mul_pipe_param.sv
// mul_pipe_param: parametrised, handshaked RV32M multiplier pipeline.
//
// Shift-add partial products are accumulated over STAGES register stages.
// Each stage handles a slice of C = ceil(WIDTH/STAGES) multiplicand bits.
// Operands enter as sign-magnitude, and the last stage applies the final
// negation and selects the requested half of the product.
//
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   flush             synchronous kill of every in-flight op
//   in_valid/in_ready request handshake
//   in_op             00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_a, in_b        multiplicand (rs1), multiplier (rs2)
//   in_tag            opaque tag carried to out_tag
//   out_valid/out_ready result handshake
//   out_result        selected WIDTH-bit half of the product
//   out_tag           tag of the presented result
module mul_pipe_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned C  = (WIDTH + STAGES - 1) / STAGES;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  // Per-stage inputs: index k is what stage k consumes (from issue or stage k-1).
  logic [STAGES-1:0] s_vin;
  logic [PW-1:0]     s_acc [STAGES];
  logic [WIDTH-1:0]  s_ma  [STAGES];
  logic [WIDTH-1:0]  s_mb  [STAGES];
  logic              s_neg [STAGES];
  op_e               s_op  [STAGES];
  logic [TAG_W-1:0]  s_tag [STAGES];

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  // Issue: sign detection and magnitude formation.
  op_e              issue_op;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    issue_op = op_e'(in_op);
    sign_a   = in_a[WIDTH-1] & ((issue_op == OP_MULH) | (issue_op == OP_MULHSU));
    sign_b   = in_b[WIDTH-1] & (issue_op == OP_MULH);
    mag_a    = sign_a ? -in_a : in_a;
    mag_b    = sign_b ? -in_b : in_b;
  end

  assign s_vin[0] = in_valid;
  assign s_acc[0] = '0;
  assign s_ma[0]  = mag_a;
  assign s_mb[0]  = mag_b;
  assign s_neg[0] = sign_a ^ sign_b;
  assign s_op[0]  = issue_op;
  assign s_tag[0] = in_tag;

  // Advance chain, evaluated from the output backwards: a stage moves when
  // it is empty or the stage after it moves.
  always_comb begin : p_adv
    logic run;
    run = out_ready;
    adv = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      run                 = ~vld[STAGES-1-j] | run;
      adv[STAGES-1-j]     = run;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = vld[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * C;
    localparam int unsigned HI = ((k + 1) * C < WIDTH) ? (k + 1) * C : WIDTH;

    logic [PW-1:0] acc_nx;

    always_comb begin
      acc_nx = s_acc[k];
      for (int unsigned i = LO; i < HI; i++) begin
        if (s_ma[k][i]) acc_nx = acc_nx + ({{WIDTH{1'b0}}, s_mb[k]} << i);
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic             valid_q;
      logic [PW-1:0]    acc_q;
      logic [WIDTH-1:0] ma_q;
      logic [WIDTH-1:0] mb_q;
      logic             neg_q;
      op_e              op_q;
      logic [TAG_W-1:0] tag_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_q <= 1'b0;
          acc_q   <= '0;
          ma_q    <= '0;
          mb_q    <= '0;
          neg_q   <= 1'b0;
          op_q    <= OP_MUL;
          tag_q   <= '0;
        end else begin
          if (flush)       valid_q <= 1'b0;
          else if (adv[k]) valid_q <= s_vin[k];
          if (adv[k] && s_vin[k] && !flush) begin
            acc_q <= acc_nx;
            ma_q  <= s_ma[k];
            mb_q  <= s_mb[k];
            neg_q <= s_neg[k];
            op_q  <= s_op[k];
            tag_q <= s_tag[k];
          end
        end
      end

      assign vld[k]     = valid_q;
      assign s_vin[k+1] = valid_q;
      assign s_acc[k+1] = acc_q;
      assign s_ma[k+1]  = ma_q;
      assign s_mb[k+1]  = mb_q;
      assign s_neg[k+1] = neg_q;
      assign s_op[k+1]  = op_q;
      assign s_tag[k+1] = tag_q;
    end else begin : g_last
      // The final stage stores only the selected half, not the accumulator,
      // so the output register doubles as the last pipeline register.
      logic [PW-1:0]    prod;
      logic [WIDTH-1:0] res_nx;
      logic             valid_q;
      logic [WIDTH-1:0] res_q;
      logic [TAG_W-1:0] tag_q;

      always_comb begin
        prod   = s_neg[k] ? -acc_nx : acc_nx;
        res_nx = (s_op[k] == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          valid_q <= 1'b0;
          res_q   <= '0;
          tag_q   <= '0;
        end else begin
          if (flush)       valid_q <= 1'b0;
          else if (adv[k]) valid_q <= s_vin[k];
          if (adv[k] && s_vin[k] && !flush) begin
            res_q <= res_nx;
            tag_q <= s_tag[k];
          end
        end
      end

      assign vld[k]     = valid_q;
      assign out_result = res_q;
      assign out_tag    = tag_q;
    end
  end

endmodule

// File: tb/tb_mul_pipe_param.sv
module tb_mul_pipe_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, STAGES=3
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  mul_pipe_param #(.WIDTH(32), .STAGES(3), .TAG_W(5)) dut (
    .CLK(clk), .RST_N(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // Sweep instances: WIDTH=8, STAGES 1, 3, 8
  logic       sv_flush;
  logic [2:0] sv_valid, sv_irdy, sv_ovld, sv_ordy;
  logic [1:0] sv_op  [3];
  logic [7:0] sv_a   [3];
  logic [7:0] sv_b   [3];
  logic [7:0] sv_res [3];
  logic [4:0] sv_tag [3];
  logic [4:0] sv_otag[3];

  mul_pipe_param #(.WIDTH(8), .STAGES(1), .TAG_W(5)) u_s1 (
    .CLK(clk), .RST_N(rst_n), .flush(sv_flush),
    .in_valid(sv_valid[0]), .in_ready(sv_irdy[0]), .in_op(sv_op[0]),
    .in_a(sv_a[0]), .in_b(sv_b[0]), .in_tag(sv_tag[0]),
    .out_valid(sv_ovld[0]), .out_ready(sv_ordy[0]),
    .out_result(sv_res[0]), .out_tag(sv_otag[0])
  );
  mul_pipe_param #(.WIDTH(8), .STAGES(3), .TAG_W(5)) u_s3 (
    .CLK(clk), .RST_N(rst_n), .flush(sv_flush),
    .in_valid(sv_valid[1]), .in_ready(sv_irdy[1]), .in_op(sv_op[1]),
    .in_a(sv_a[1]), .in_b(sv_b[1]), .in_tag(sv_tag[1]),
    .out_valid(sv_ovld[1]), .out_ready(sv_ordy[1]),
    .out_result(sv_res[1]), .out_tag(sv_otag[1])
  );
  mul_pipe_param #(.WIDTH(8), .STAGES(8), .TAG_W(5)) u_s8 (
    .CLK(clk), .RST_N(rst_n), .flush(sv_flush),
    .in_valid(sv_valid[2]), .in_ready(sv_irdy[2]), .in_op(sv_op[2]),
    .in_a(sv_a[2]), .in_b(sv_b[2]), .in_tag(sv_tag[2]),
    .out_valid(sv_ovld[2]), .out_ready(sv_ordy[2]),
    .out_result(sv_res[2]), .out_tag(sv_otag[2])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sign-extend per op, multiply in 64-bit arithmetic, pick a half.
  function automatic logic [31:0] ref_mul(input int unsigned w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, ax, bx, p, r;
    m  = (64'd1 << w) - 64'd1;
    ax = {32'b0, a} & m;
    bx = {32'b0, b} & m;
    if ((op == 2'b01 || op == 2'b10) && a[w-1]) ax = ax - (64'd1 << w);
    if (op == 2'b01 && b[w-1])                   bx = bx - (64'd1 << w);
    p = ax * bx;
    r = (op == 2'b00) ? (p & m) : ((p >> w) & m);
    return r[31:0];
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  c_op  [7];
    logic [31:0] c_a   [7];
    logic [31:0] c_b   [7];
    logic [31:0] c_exp [7];
    logic [1:0]  bp_op [4];
    logic [31:0] bp_a  [4];
    logic [31:0] bp_b  [4];
    logic [31:0] bp_exp[4];
    logic [31:0] e32;
    int          acc_n;
    logic        took;
    int          s_of    [3];
    int          issued  [3];
    int          got     [3];
    int          head    [3];
    int          tail    [3];
    logic        pend    [3];
    logic        acc_f   [3];
    logic [7:0]  q_res   [3][16];
    logic [4:0]  q_tag   [3][16];
    int          q_cyc   [3][16];
    int          q_seq   [3][16];
    logic        all_done;

    c_op[0] = 2'b01; c_a[0] = 32'h8000_0000; c_b[0] = 32'h8000_0000; c_exp[0] = 32'h4000_0000;
    c_op[1] = 2'b01; c_a[1] = 32'hFFFF_FFFF; c_b[1] = 32'h0000_0001; c_exp[1] = 32'hFFFF_FFFF;
    c_op[2] = 2'b10; c_a[2] = 32'hFFFF_FFFF; c_b[2] = 32'hFFFF_FFFF; c_exp[2] = 32'hFFFF_FFFF;
    c_op[3] = 2'b00; c_a[3] = 32'hFFFF_FFFF; c_b[3] = 32'hFFFF_FFFF; c_exp[3] = 32'h0000_0001;
    c_op[4] = 2'b00; c_a[4] = 32'h0000_0000; c_b[4] = 32'h1234_5678; c_exp[4] = 32'h0000_0000;
    c_op[5] = 2'b11; c_a[5] = 32'hDEAD_BEEF; c_b[5] = 32'h0000_0000; c_exp[5] = 32'h0000_0000;
    c_op[6] = 2'b10; c_a[6] = 32'h8000_0000; c_b[6] = 32'h0000_0000; c_exp[6] = 32'h0000_0000;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    sv_flush = 1'b0; sv_valid = '0; sv_ordy = '0;
    s_of[0] = 1; s_of[1] = 3; s_of[2] = 8;
    for (int j = 0; j < 3; j++) begin
      sv_op[j] = '0; sv_a[j] = '0; sv_b[j] = '0; sv_tag[j] = '0;
      issued[j] = 0; got[j] = 0; head[j] = 0; tail[j] = 0;
      pend[j] = 1'b0; acc_f[j] = 1'b0;
    end

    // Reset
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // MUL 7x6 then back-to-back MULHU
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd7; in_b = 32'd6; in_tag = 5'd3;
    #1 chk("mul_accept", in_ready, 1);
    tick();
    chk("mul_lat1_idle", out_valid, 0);
    in_op = 2'b11; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 5'd4;
    #1 chk("mulhu_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("mul_lat2_idle", out_valid, 0);
    tick();
    chk("mul_valid", out_valid, 1);
    chk("mul_result", out_result, 42);
    chk("mul_tag", out_tag, 3);
    tick();
    chk("mulhu_valid", out_valid, 1);
    chk("mulhu_result", out_result, 32'hFFFF_FFFE);
    chk("mulhu_tag", out_tag, 4);
    tick();
    chk("pipe_idle", out_valid, 0);

    // Signed corners and zero cases, streamed back to back
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        in_valid = 1'b1; in_op = c_op[i]; in_a = c_a[i]; in_b = c_b[i]; in_tag = 5'(i + 8);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 2) begin
        chk($sformatf("corner%0d_valid", i - 2), out_valid, 1);
        chk($sformatf("corner%0d_result", i - 2), out_result, c_exp[i - 2]);
        chk($sformatf("corner%0d_tag", i - 2), out_tag, 5'(i + 6));
      end
    end
    in_valid = 1'b0;
    repeat (2) tick();

    // Back-pressure: offer 4 ops with out_ready low
    for (int i = 0; i < 4; i++) begin
      bp_op[i] = 2'($urandom_range(0, 3));
      bp_a[i]  = $urandom;
      bp_b[i]  = $urandom;
      bp_exp[i] = ref_mul(32, bp_op[i], bp_a[i], bp_b[i]);
    end
    out_ready = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 4; c++) begin
      if (acc_n < 4) begin
        in_valid = 1'b1; in_op = bp_op[acc_n]; in_a = bp_a[acc_n];
        in_b = bp_b[acc_n]; in_tag = 5'(acc_n);
      end else begin
        in_valid = 1'b0;
      end
      #1 took = in_valid & in_ready;
      tick();
      if (took) acc_n++;
    end
    if (acc_n < 4) begin
      in_op = bp_op[acc_n]; in_a = bp_a[acc_n]; in_b = bp_b[acc_n]; in_tag = 5'(acc_n);
    end
    chk("bp_accept_count", acc_n, 3);
    #1 chk("bp_in_ready_low", in_ready, 0);
    for (int c = 0; c < 2; c++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, bp_exp[0]);
      chk("bp_hold_tag", out_tag, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_valid", k), out_valid, 1);
      chk($sformatf("bp_drain%0d_tag", k), out_tag, 5'(k));
      chk($sformatf("bp_drain%0d_result", k), out_result, bp_exp[k]);
      took = in_valid & in_ready;
      tick();
      if (took) begin
        acc_n++;
        if (acc_n < 4) begin
          in_op = bp_op[acc_n]; in_a = bp_a[acc_n]; in_b = bp_b[acc_n]; in_tag = 5'(acc_n);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", acc_n, 4);
    repeat (3) tick();

    // Flush two in-flight ops
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd5; in_b = 32'd9; in_tag = 5'd10;
    tick();
    in_a = 32'd11; in_tag = 5'd11;
    tick();
    flush = 1'b1; in_a = 32'd13; in_tag = 5'd12;
    #1 chk("flush_in_ready_low", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("flush_no_out", out_valid, 0);
      tick();
    end
    in_valid = 1'b1; in_op = 2'b01; in_a = $urandom; in_b = $urandom; in_tag = 5'd20;
    e32 = ref_mul(32, 2'b01, in_a, in_b);
    #1 chk("post_flush_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_flush_early", out_valid, 0);
    tick();
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_result", out_result, e32);
    chk("post_flush_tag", out_tag, 20);
    tick();

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b11; in_a = 32'h0001_0000; in_b = 32'h0003_0000; in_tag = 5'd21;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("prerst_valid", out_valid, 1);
    chk("prerst_result", out_result, 32'h0000_0003);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_result", out_result, 0);
    chk("async_rst_tag", out_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("async_rst_in_ready", in_ready, 1);

    // WIDTH=8 sweep: first ops with out_ready held high, then random back-pressure
    for (int cyc = 0; cyc < 20000; cyc++) begin
      all_done = 1'b1;
      for (int j = 0; j < 3; j++) if (got[j] < 1000) all_done = 1'b0;
      if (all_done) break;
      for (int j = 0; j < 3; j++) begin
        if (!pend[j]) begin
          if (issued[j] < 1000) begin
            sv_valid[j] = 1'b1;
            sv_op[j]    = 2'($urandom_range(0, 3));
            sv_a[j]     = 8'($urandom);
            sv_b[j]     = 8'($urandom);
            sv_tag[j]   = 5'(issued[j]);
            pend[j]     = 1'b1;
          end else begin
            sv_valid[j] = 1'b0;
          end
        end
        sv_ordy[j] = (issued[j] < 100) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      for (int j = 0; j < 3; j++) begin
        if (sv_ovld[j] && sv_ordy[j]) begin
          if (head[j] == tail[j]) begin
            chk($sformatf("sweep_s%0d_spurious", s_of[j]), sv_ovld[j], 0);
          end else begin
            chk($sformatf("sweep_s%0d_result", s_of[j]), sv_res[j], q_res[j][head[j]]);
            chk($sformatf("sweep_s%0d_tag", s_of[j]), sv_otag[j], q_tag[j][head[j]]);
            if (q_seq[j][head[j]] < 90)
              chk($sformatf("sweep_s%0d_latency", s_of[j]), cyc - q_cyc[j][head[j]], s_of[j]);
            else
              chk($sformatf("sweep_s%0d_latency_min", s_of[j]),
                  (cyc - q_cyc[j][head[j]]) >= s_of[j], 1);
            head[j] = (head[j] + 1) % 16;
            got[j]++;
          end
        end
        acc_f[j] = sv_valid[j] & sv_irdy[j];
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        if (acc_f[j]) begin
          q_res[j][tail[j]] = ref_mul(8, sv_op[j], {24'b0, sv_a[j]}, {24'b0, sv_b[j]}) & 32'hFF;
          q_tag[j][tail[j]] = sv_tag[j];
          q_cyc[j][tail[j]] = cyc;
          q_seq[j][tail[j]] = issued[j];
          tail[j] = (tail[j] + 1) % 16;
          issued[j]++;
          pend[j] = 1'b0;
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      sv_valid[j] = 1'b0;
      chk($sformatf("sweep_s%0d_completed", s_of[j]), got[j], 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_pipe_param.md
Name: mul_pipe_param

Overview:
- Parametrised, handshaked successor to the fixed three-slice multiplier pipeline.
- Splits the shift-add partial-product accumulation across STAGES registered stages, with sign-magnitude handling and final negation.
- Supports all four RV32M multiply ops, valid/ready flow control with back-pressure, an opaque tag for writeback, and synchronous flush.
- Sits between M-extension decode/issue and writeback in the execute path.

Parameters:
- WIDTH, 32, operand width in bits; result width is WIDTH.
- STAGES, 3, number of pipeline register stages (1..WIDTH); slice size C = ceil(WIDTH/STAGES).
- TAG_W, 5, width of the passthrough tag (e.g. rd index).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept the request this cycle.
- in_op  in  2  00 MUL (low half), 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u).
- in_a  in  WIDTH  multiplicand (rs1).
- in_b  in  WIDTH  multiplier (rs2).
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  selected half of the product.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (RST_N=0, async): all stage valid bits 0; out_result and out_tag 0; all internal accumulators 0. in_ready is 1 once RST_N=1.
- Accept occurs when in_valid & in_ready at a rising edge. Issue stage computes signA = in_a[WIDTH-1] & (op==01 | op==10), and signB = in_b[WIDTH-1] & (op==01).
- Magnitudes |a|, |b| are formed with two's-complement negate when the respective sign bit is set. negate = signA ^ signB.
- Stage k (0..STAGES-1):
  - Adds ({WIDTH'b0,|b|} << i) for each i in [k*C, min((k+1)*C, WIDTH)-1] where |a|[i]=1.
  - Uses a 2*WIDTH-bit accumulator carried from stage k-1; stage 0 starts from 0.
  - Carries |a|, |b|, negate, op, and tag alongside.
- Last stage: after accumulation, product = negate ? -acc : acc (2*WIDTH bits, modulo 2^(2*WIDTH)). It then registers out_result = (op==00) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH].
- Latency: exactly STAGES cycles from accept edge to out_valid with no stall. Throughput is one op per cycle.
- Flow control:
  - Stage k advances when it holds nothing or stage k+1 advances. The last stage advances when !out_valid | out_ready.
  - in_ready = (!valid[0] | advance[0]) & !flush.
  - A stalled stage holds all its registers unchanged.
  - out_result/out_tag are stable while out_valid & !out_ready.
- Flush: at the edge where flush=1, all valid bits clear, so out_valid=0 the next cycle. No request is accepted on that edge; in_ready=0 during the flush cycle. Data registers may retain stale values.
- Flush and out_ready together: the flush wins; the result presented in that cycle counts as consumed only if out_valid & out_ready.
- Op boundary values:
  - MUL and MULHU of 0 give 0.
  - MULH(0x80000000, 0x80000000) gives 0x40000000.
  - MULHSU with negative a and b=0 gives 0, with no negative zero: negate of 0 is 0.
- Reset mid-operation: all in-flight ops are lost and outputs go to reset values immediately (async).
- STAGES=1: single register, latency 1. STAGES=WIDTH: one bit per stage.

Test Plan:
- Reset then idle: RST_N low 2 cycles -> out_valid=0, out_result=0, in_ready=1 after release.
- MUL 7×6, tag 3, out_ready=1 -> after exactly 3 cycles out_valid=1, out_result=42, out_tag=3. Back-to-back MULHU(0xFFFFFFFF, 0xFFFFFFFF) next cycle -> 0xFFFFFFFE on the following cycle.
- Signed corners (WIDTH=32):
  - MULH(0x80000000, 0x80000000) -> 0x40000000.
  - MULH(0xFFFFFFFF, 1) -> 0xFFFFFFFF.
  - MULHSU(0xFFFFFFFF, 0xFFFFFFFF) -> 0xFFFFFFFF.
  - MUL(0xFFFFFFFF, 0xFFFFFFFF) -> 0x00000001.
- Back-pressure:
  - Issue 4 ops with out_ready=0 -> exactly STAGES ops accepted, in_ready=0 afterwards, out_result held stable.
  - Raise out_ready -> results drain in order, one per cycle, tags 0..3.
- Flush: issue 2 ops, assert flush for 1 cycle at cycle 2 -> no out_valid for those ops, in_ready=0 during flush. A new op accepted after flush returns a correct result at latency STAGES.
- Parameter sweep: WIDTH=8 with STAGES ∈ {1, 3, 8} against a random reference model (1000 ops each, random out_ready) -> all results match, latency equals STAGES with no stalls.
